// File: rtl/register_bank.sv
// register_bank: accumulator-style register file for a small N-bit CPU.
// Four N-bit registers (A, B, OUT, PC) and a carry flag C. All of them are
// fed from one shared adder, SUM = OPND + IM.
// On each enabled edge, every register whose LOAD bit is set takes SUM.
// When it is not loaded, PC increments instead.
// Optional feature: define REGISTER_BANK_OUT_STB_EN to add the registered
// OUT_STB port, which pulses for the cycle after each OUT load.
module register_bank #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         NRST,
  input  logic         EN,
  input  logic [N-1:0] OPND,
  input  logic [N-1:0] IM,
  input  logic [3:0]   LOAD,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] OUT,
  output logic [N-1:0] PC,
  output logic         C
`ifdef REGISTER_BANK_OUT_STB_EN
  ,
  output logic         OUT_STB
`endif
);

  // Bit positions inside LOAD.
  localparam int LdA   = 0;
  localparam int LdB   = 1;
  localparam int LdOut = 2;
  localparam int LdPc  = 3;

  logic [N:0]   sum;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] pc_q, pc_d;
  logic         c_q, c_d;

  // Shared adder with no carry-in. The extra top bit is the carry-out.
  always_comb begin
    sum = {1'b0, OPND} + {1'b0, IM};
  end

  // Next-state selection. Old A/B values feed OPND, so this is read-before-write.
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path can leave it unassigned and infer a latch.
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    if (EN) begin
      if (LOAD[LdA])   a_d   = sum[N-1:0];
      if (LOAD[LdB])   b_d   = sum[N-1:0];
      if (LOAD[LdOut]) out_d = sum[N-1:0];
      pc_d = LOAD[LdPc] ? sum[N-1:0] : pc_q + N'(1);
      c_d  = sum[N];
    end
  end

  // State registers. The synchronous reset takes priority over EN and LOAD.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!NRST) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign A   = a_q;
  assign B   = b_q;
  assign OUT = out_q;
  assign PC  = pc_q;
  assign C   = c_q;

`ifdef REGISTER_BANK_OUT_STB_EN
  logic stb_q;
  logic stb_d;

  // The strobe is high exactly when the previous edge was enabled and loaded OUT.
  always_comb begin
    stb_d = EN & LOAD[LdOut];
  end

  // Strobe register. Reset clears it together with the rest of the state.
  always_ff @(posedge CLK) begin
    if (!NRST) stb_q <= 1'b0;
    else       stb_q <= stb_d;
  end

  assign OUT_STB = stb_q;
`endif

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed and randomized checks of register_bank.
// A behavioural reference model supplies the expected values.
// Define REGISTER_BANK_OUT_STB_EN to also check the OUT_STB port.
module tb_register_bank;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic         CLK;
  logic         NRST;
  logic         EN;
  logic [N-1:0] OPND;
  logic [N-1:0] IM;
  logic [3:0]   LOAD;
  logic [N-1:0] A, B, OUT, PC;
  logic         C;
`ifdef REGISTER_BANK_OUT_STB_EN
  logic         OUT_STB;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [N-1:0] m_a, m_b, m_out, m_pc;
  logic         m_c, m_stb;

  register_bank #(.N(N)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .OPND(OPND), .IM(IM), .LOAD(LOAD),
    .A(A), .B(B), .OUT(OUT), .PC(PC), .C(C)
`ifdef REGISTER_BANK_OUT_STB_EN
    , .OUT_STB(OUT_STB)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [4*N:0] obs_vec();
    return {A, B, OUT, PC, C};
  endfunction

  function automatic logic [4*N:0] exp_vec();
    return {m_a, m_b, m_out, m_pc, m_c};
  endfunction

  // Model of one clock edge, written from the plain arithmetic rules.
  task automatic model_step(input logic nrst, input logic en, input logic [3:0] ld,
                            input logic [N-1:0] op, input logic [N-1:0] im);
    int s;
    int r;
    if (!nrst) begin
      m_a = '0; m_b = '0; m_out = '0; m_pc = '0; m_c = 1'b0; m_stb = 1'b0;
    end else if (en) begin
      s = int'(op) + int'(im);
      r = s % MOD;
      if (ld[0]) m_a   = N'(r);
      if (ld[1]) m_b   = N'(r);
      if (ld[2]) m_out = N'(r);
      m_pc  = ld[3] ? N'(r) : N'((int'(m_pc) + 1) % MOD);
      m_c   = (s >= MOD);
      m_stb = ld[2];
    end else begin
      m_stb = 1'b0;
    end
  endtask

  // Drive one instruction after the edge, advance the model, then wait past the next rising edge.
  task automatic apply(input logic nrst, input logic en, input logic [3:0] ld,
                       input logic [N-1:0] op, input logic [N-1:0] im);
    NRST = nrst; EN = en; LOAD = ld; OPND = op; IM = im;
    model_step(nrst, en, ld, op, im);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 4'b1111, 4'd5, 4'd3);
    checks++;
    if (obs_vec() !== 17'h0) begin
      errors++;
      $display("FAIL reset got %h expected %h", obs_vec(), 17'h0);
    end
`ifdef REGISTER_BANK_OUT_STB_EN
    checks++;
    if (OUT_STB !== 1'b0) begin
      errors++;
      $display("FAIL reset_stb got %b expected 0", OUT_STB);
    end
`endif
  endtask

  task automatic test_load_a();
    apply(1'b1, 1'b1, 4'b0001, 4'd3, 4'd4);
    checks++;
    if (obs_vec() !== {4'h7, 4'h0, 4'h0, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL load_a got %h expected %h", obs_vec(), {4'h7, 4'h0, 4'h0, 4'h1, 1'b0});
    end
  endtask

  task automatic test_carry();
    apply(1'b1, 1'b1, 4'b0010, 4'd9, 4'd8);
    checks++;
    if (obs_vec() !== {4'h7, 4'h1, 4'h0, 4'h2, 1'b1}) begin
      errors++;
      $display("FAIL carry_set got %h expected %h", obs_vec(), {4'h7, 4'h1, 4'h0, 4'h2, 1'b1});
    end
    apply(1'b1, 1'b1, 4'b0000, 4'd0, 4'd0);
    checks++;
    if (obs_vec() !== {4'h7, 4'h1, 4'h0, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL carry_clear got %h expected %h", obs_vec(), {4'h7, 4'h1, 4'h0, 4'h3, 1'b0});
    end
  endtask

  task automatic test_pc_wrap();
    apply(1'b0, 1'b0, 4'b0000, 4'd0, 4'd0);
    for (int i = 0; i < 15; i++) apply(1'b1, 1'b1, 4'b0000, 4'd0, 4'd0);
    checks++;
    if (PC !== 4'hF) begin
      errors++;
      $display("FAIL pc_top got %h expected f", PC);
    end
    apply(1'b1, 1'b1, 4'b0000, 4'd0, 4'd0);
    checks++;
    if (obs_vec() !== 17'h0) begin
      errors++;
      $display("FAIL pc_wrap got %h expected %h", obs_vec(), 17'h0);
    end
    apply(1'b1, 1'b1, 4'b1000, 4'd0, 4'hA);
    checks++;
    if (obs_vec() !== {4'h0, 4'h0, 4'h0, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL pc_jump got %h expected %h", obs_vec(), {4'h0, 4'h0, 4'h0, 4'hA, 1'b0});
    end
  endtask

  task automatic test_hold_multi();
    apply(1'b1, 1'b0, 4'b1111, 4'd7, 4'd7);
    checks++;
    if (obs_vec() !== {4'h0, 4'h0, 4'h0, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL hold got %h expected %h", obs_vec(), {4'h0, 4'h0, 4'h0, 4'hA, 1'b0});
    end
    apply(1'b1, 1'b1, 4'b0111, 4'd2, 4'd2);
    checks++;
    if (obs_vec() !== {4'h4, 4'h4, 4'h4, 4'hB, 1'b0}) begin
      errors++;
      $display("FAIL multi_load got %h expected %h", obs_vec(), {4'h4, 4'h4, 4'h4, 4'hB, 1'b0});
    end
`ifdef REGISTER_BANK_OUT_STB_EN
    checks++;
    if (OUT_STB !== 1'b1) begin
      errors++;
      $display("FAIL multi_stb got %b expected 1", OUT_STB);
    end
`endif
    apply(1'b1, 1'b0, 4'b0100, 4'd1, 4'd1);
    checks++;
    if (obs_vec() !== {4'h4, 4'h4, 4'h4, 4'hB, 1'b0}) begin
      errors++;
      $display("FAIL hold_after got %h expected %h", obs_vec(), {4'h4, 4'h4, 4'h4, 4'hB, 1'b0});
    end
`ifdef REGISTER_BANK_OUT_STB_EN
    checks++;
    if (OUT_STB !== 1'b0) begin
      errors++;
      $display("FAIL hold_stb got %b expected 0", OUT_STB);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ops [4] = '{4'd1, 4'd3, 4'd0, 4'd0};
    logic [N-1:0] ims [4] = '{4'd1, 4'd0, 4'd5, 4'd0};
    logic [3:0]   lds [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [N-1:0] outs [4] = '{4'd2, 4'd3, 4'd5, 4'd5};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, lds[i], ops[i], ims[i]);
      checks++;
      if (OUT !== outs[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d] got %h expected %h", i, OUT, outs[i]);
      end
`ifdef REGISTER_BANK_OUT_STB_EN
      checks++;
      if (OUT_STB !== (i < 3)) begin
        errors++;
        $display("FAIL b2b_stb[%0d] got %b expected %b", i, OUT_STB, (i < 3));
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b0, 1'b1, 4'b1111, 4'd1, 4'd1);
    apply(1'b1, 1'b1, 4'b0001, 4'd3, 4'd4);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 4'b0000, 4'd0, 4'd0);
    checks++;
    if (obs_vec() !== {4'h7, 4'h0, 4'h0, 4'h5, 1'b0}) begin
      errors++;
      $display("FAIL mid_setup got %h expected %h", obs_vec(), {4'h7, 4'h0, 4'h0, 4'h5, 1'b0});
    end
    apply(1'b0, 1'b1, 4'b0001, 4'd3, 4'd4);
    checks++;
    if (obs_vec() !== 17'h0) begin
      errors++;
      $display("FAIL mid_reset got %h expected %h", obs_vec(), 17'h0);
    end
  endtask

  task automatic test_random();
    logic       nrst, en;
    logic [3:0] ld;
    logic [N-1:0] op, im;
    for (int i = 0; i < 400; i++) begin
      nrst = ($urandom_range(0, 19) != 0);
      en   = ($urandom_range(0, 3) != 0);
      ld   = 4'($urandom);
      im   = N'($urandom);
      case ($urandom_range(0, 3))
        0:       op = m_a;
        1:       op = m_b;
        default: op = N'($urandom);
      endcase
      apply(nrst, en, ld, op, im);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] got %h expected %h", i, obs_vec(), exp_vec());
      end
`ifdef REGISTER_BANK_OUT_STB_EN
      checks++;
      if (OUT_STB !== m_stb) begin
        errors++;
        $display("FAIL random_stb[%0d] got %b expected %b", i, OUT_STB, m_stb);
      end
`endif
    end
  endtask

  initial begin
    NRST = 1'b0; EN = 1'b0; LOAD = 4'b0; OPND = '0; IM = '0;
    m_a = '0; m_b = '0; m_out = '0; m_pc = '0; m_c = 1'b0; m_stb = 1'b0;
    #1;
    test_reset();
    test_load_a();
    test_carry();
    test_pc_wrap();
    test_hold_multi();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter: N, default 4, datapath width of every register, the adder and the operand ports.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 NRST  input  1  reset; synchronous, active-low.
REQ-004 EN  input  1  step enable; 1 = execute one instruction this cycle, 0 = hold all state.
REQ-005 OPND  input  N  operand from upstream data selector output Y.
REQ-006 IM  input  N  immediate field of current instruction.
REQ-007 LOAD  input  4  load enables: bit0 = A, bit1 = B, bit2 = OUT, bit3 = PC.
REQ-008 A  output  N  register A; feeds data selector input.
REQ-009 B  output  N  register B; feeds data selector input.
REQ-010 OUT  output  N  output port register.
REQ-011 PC  output  N  program counter.
REQ-012 C  output  1  carry flag.
REQ-013 OUT_STB  output  1  OUT-write strobe; present only with REGISTER_BANK_OUT_STB_EN (REQ-031).

Function
REQ-014 Adder: combinational SUM[N:0] = {1'b0,OPND} + {1'b0,IM}; no carry-in.
REQ-015 On CLK rise with NRST=1, EN=1: each register whose LOAD bit is 1 takes SUM[N-1:0].
REQ-016 Registers A, B, OUT with LOAD bit 0 hold their value.
REQ-017 PC with LOAD[3]=0: PC <= PC + 1 modulo 2^N; PC = all-ones wraps to 0, no flag.
REQ-018 PC with LOAD[3]=1: PC <= SUM[N-1:0]; no increment applied that cycle.
REQ-019 C <= SUM[N] every enabled cycle, regardless of LOAD.
REQ-020 Multiple LOAD bits set simultaneously: all selected registers load the same SUM in the same edge.
REQ-021 LOAD = 0000 with EN=1: only PC increments and C updates (NOP/carry-probe).
REQ-022 EN=0: A, B, OUT, PC, C all hold; LOAD, OPND, IM ignored.
REQ-023 Latency: one cycle; new values visible on outputs immediately after the edge.
REQ-024 Outputs are direct register outputs; no combinational path from any input to A, B, OUT, PC, C.
REQ-025 OPND may combinationally depend on A/B; read-before-write per edge (old A/B used for SUM).

Reset
REQ-026 NRST=0 at a CLK rise: A, B, OUT, PC = 0, C = 0, OUT_STB = 0.
REQ-027 Reset has priority over EN and LOAD.
REQ-028 Reset mid-operation (any state, any LOAD): applied at next edge; no partial update.
REQ-029 First enabled cycle after reset release executes instruction at PC = 0.
REQ-030 Outputs undefined only before first reset edge; bench shall reset before checking.

Configuration
REQ-031 REGISTER_BANK_OUT_STB_EN defined: OUT_STB port exists; registered, =1 for exactly the cycle after an enabled edge with LOAD[2]=1, else 0; back-to-back OUT loads keep OUT_STB high continuously.
REQ-032 REGISTER_BANK_OUT_STB_EN undefined: OUT_STB port and its logic absent; all other behaviour identical.

Verification
REQ-033 Reset: NRST=0 one edge with EN=1, LOAD=1111, OPND=5, IM=3 -> A=B=OUT=PC=0, C=0.
REQ-034 Load A: EN=1, LOAD=0001, OPND=3, IM=4 -> A=7, C=0, PC=1, B/OUT unchanged.
REQ-035 Carry: N=4, LOAD=0010, OPND=9, IM=8 -> B=1, C=1; next edge LOAD=0000, OPND=0, IM=0 -> C=0.
REQ-036 PC wrap/jump: 16 edges LOAD=0000 from reset -> PC=0 again; then LOAD=1000, OPND=0, IM=A -> PC=A.
REQ-037 Hold and multi-load: EN=0 with LOAD=1111 -> no change; EN=1, LOAD=0111, OPND=2, IM=2 -> A=B=OUT=4, OUT_STB=1 next cycle (when macro defined).
REQ-038 Mid-run reset: after A=7, PC=5, assert NRST=0 with EN=1, LOAD=0001 -> all outputs 0 after edge.
